// File: rtl/alu_slave_pkg.sv
// Shared constants for the ALU bus slave: opcodes, FSM states, register offsets.
package alu_slave_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_NOT = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_ADD = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_LSL = 4'd7;
  localparam logic [3:0] OP_LSR = 4'd8;
  localparam logic [3:0] OP_ASR = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [7:0] REG_OPSTART   = 8'h00;
  localparam logic [7:0] REG_OPCLEAR   = 8'h01;
  localparam logic [7:0] REG_INTR_EN   = 8'h02;
  localparam logic [7:0] REG_INST_PUSH = 8'h03;
  localparam logic [7:0] REG_RES_POP   = 8'h05;
  localparam logic [7:0] REG_STATUS    = 8'h06;
  localparam logic [7:0] REG_INTR      = 8'h07;
  localparam logic [3:0] REG_OPERAND_HI = 4'h1;

endpackage

// File: rtl/alu_fifo.sv
// Synchronous FIFO with combinational head, clear, and full/empty/count flags.
module alu_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is still taken when a pop frees a slot in the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rptr];

  // Pointer and occupancy tracking; clear outranks any concurrent push/pop.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/alu_bus_slave.sv
// Bus-slave ALU: executes queued instruction words on a 16-entry operand file.
module alu_bus_slave
  import alu_slave_pkg::*;
#(
  parameter int INST_DEPTH = 8,
  parameter int RES_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_sel,
  input  logic        s_wr,
  input  logic [15:0] s_addr,
  input  logic [31:0] s_din,
  output logic [31:0] s_dout,
  output logic        s_interrupt
);

  localparam int IC_W = $clog2(INST_DEPTH) + 1;
  localparam int RC_W = $clog2(RES_DEPTH) + 1;

  function automatic logic [31:0] alu_calc(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [31:0] sa;
    logic [31:0]        r;
    sa = a;
    r  = '0;
    case (op)
      OP_NOT: r = ~a;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_LSL: r = a << b[4:0];
      OP_LSR: r = a >> b[4:0];
      OP_ASR: r = sa >>> b[4:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t      state, state_nx;
  logic [31:0] operand [16];
  logic        intr_en, ovf, unf, done_flag;
  logic [7:0]  off;
  logic        wr_acc, rd_acc;
  logic        start_wr, clear_wr, ack_wr, push_wr, pop_rd, oper_wr;
  logic        inst_pop, res_push;
  logic [31:0] inst_head, res_head, alu_out;
  logic        inst_full, inst_empty, res_full, res_empty;
  logic [IC_W-1:0] inst_cnt;
  logic [RC_W-1:0] res_cnt;
  logic [3:0]  op;

  assign off      = s_addr[7:0];
  assign wr_acc   = s_sel & s_wr;
  assign rd_acc   = s_sel & ~s_wr;
  assign start_wr = wr_acc & (off == REG_OPSTART) & s_din[0];
  assign clear_wr = wr_acc & (off == REG_OPCLEAR) & s_din[0];
  assign ack_wr   = wr_acc & (off == REG_INTR);
  assign push_wr  = wr_acc & (off == REG_INST_PUSH);
  assign oper_wr  = wr_acc & (off[7:4] == REG_OPERAND_HI);
  assign pop_rd   = rd_acc & (off == REG_RES_POP);
  assign op       = inst_head[3:0];
  assign done_flag   = (state == ST_DONE) | (state == ST_FAULT);
  assign s_interrupt = intr_en & done_flag;

  wire unused_bits = &{1'b0, s_addr[15:8], inst_head[31:12]};

  alu_fifo #(.WIDTH(32), .DEPTH(INST_DEPTH)) u_inst_fifo (
    .clk(clk), .reset(reset), .clear(clear_wr), .push(push_wr), .pop(inst_pop),
    .din(s_din), .head(inst_head), .full(inst_full), .empty(inst_empty), .count(inst_cnt)
  );

  alu_fifo #(.WIDTH(32), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk(clk), .reset(reset), .clear(clear_wr), .push(res_push), .pop(pop_rd),
    .din(alu_out), .head(res_head), .full(res_full), .empty(res_empty), .count(res_cnt)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state and execute-stage control; operands are read pre-edge so a same-cycle write is not seen.
  always_comb begin
    state_nx = state;
    inst_pop = 1'b0;
    res_push = 1'b0;
    alu_out  = alu_calc(op, operand[inst_head[7:4]], operand[inst_head[11:8]]);
    case (state)
      ST_IDLE: if (start_wr) state_nx = inst_empty ? ST_DONE : ST_EXEC;
      ST_EXEC: begin
        if (inst_empty) begin
          state_nx = ST_DONE;
        end else if (op > OP_ASR) begin
          inst_pop = 1'b1;
          state_nx = ST_FAULT;
        end else if (op == OP_NOP) begin
          inst_pop = 1'b1;
        end else if (!res_full) begin
          inst_pop = 1'b1;
          res_push = 1'b1;
        end
      end
      ST_DONE: if (ack_wr) state_nx = ST_IDLE;
      default: state_nx = state;
    endcase
    if (clear_wr) state_nx = ST_IDLE;
  end

  // Sticky overflow/underflow flags.
  always_ff @(posedge clk) begin
    if (reset || clear_wr) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (push_wr && inst_full && !inst_pop) ovf <= 1'b1;
      if (pop_rd && res_empty)               unf <= 1'b1;
    end
  end

  // Host-writable configuration: interrupt enable and operand file, both kept across OPCLEAR.
  always_ff @(posedge clk) begin
    if (reset) begin
      intr_en <= 1'b0;
      for (int i = 0; i < 16; i++) operand[i] <= '0;
    end else begin
      if (wr_acc && off == REG_INTR_EN) intr_en <= s_din[0];
      if (oper_wr) operand[off[3:0]] <= s_din;
    end
  end

  // Combinational read mux.
  always_comb begin
    s_dout = '0;
    if (rd_acc) begin
      if (off[7:4] == REG_OPERAND_HI) begin
        s_dout = operand[off[3:0]];
      end else begin
        case (off)
          REG_INTR_EN: s_dout = {31'b0, intr_en};
          REG_RES_POP: s_dout = res_empty ? 32'h0 : res_head;
          REG_STATUS:  s_dout = {20'b0, 4'(res_cnt), 4'(inst_cnt), unf, ovf, state};
          REG_INTR:    s_dout = {31'b0, done_flag};
          default:     s_dout = '0;
        endcase
      end
    end
  end

endmodule
